// File: rtl/alu16_seq_ctrl.sv
// rtl/alu16_seq_ctrl.sv - request/response sequencer driving a 16-bit 74181/74182 ALU datapath
//
// Accepts one operation at a time, steers the external ALU's S/M/CNb controls and
// operands, and returns the result on a valid/ready response port.
// Single-cycle ops: ADD, SUB, AND, OR, XOR. MUL is an unsigned shift-add multiply,
// one ALU add per step.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   req_valid/req_ready          request handshake (ready only in IDLE)
//   req_op[2:0]                  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MUL, 6-7 illegal
//   req_a, req_b [15:0]          operands (MUL: multiplicand, multiplier)
//   rsp_valid/rsp_ready          response handshake
//   rsp_lo, rsp_hi [15:0]        result low / MUL high half
//   rsp_carry, rsp_err           ADD carry / SUB no-borrow, illegal opcode
//   alu_s, alu_m, alu_cnb        ALU function select, mode, carry-in (active low)
//   alu_a, alu_b [15:0]          ALU operands
//   alu_f[15:0], alu_cn16b       ALU result, carry-out (active low)
module alu16_seq_ctrl #(
  parameter int MUL_STEPS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_lo,
  output logic [15:0] rsp_hi,
  output logic        rsp_carry,
  output logic        rsp_err,
  output logic [3:0]  alu_s,
  output logic        alu_m,
  output logic        alu_cnb,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic [15:0] alu_f,
  input  logic        alu_cn16b
);

  localparam int CW = $clog2(MUL_STEPS);

  typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

  state_t          state, state_nxt;
  logic [2:0]      op_q;
  logic [15:0]     a_q;     // operand A, also the multiplicand
  logic [15:0]     b_q;     // operand B, shifted in place as Q during MUL
  logic [15:0]     p_q;     // partial product high half
  logic [CW-1:0]   cnt_q;
  logic            last_step;
  logic [15:0]     p_nxt, q_nxt;

  assign req_ready = (state == IDLE);
  assign last_step = (cnt_q == CW'(MUL_STEPS - 1));

  // One multiply step: the ALU sum (with carry) is shifted right by one across P:Q.
  assign p_nxt = {~alu_cn16b, alu_f[15:1]};
  assign q_nxt = {alu_f[0], b_q[15:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    alu_s     = 4'b1001;
    alu_m     = 1'b0;
    alu_cnb   = 1'b1;
    alu_a     = 16'h0000;
    alu_b     = 16'h0000;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_op <= 3'd4)      state_nxt = EXEC;
          else if (req_op == 3'd5) state_nxt = MUL;
          else                     state_nxt = DONE;
        end
      end
      EXEC: begin
        state_nxt = DONE;
        alu_a     = a_q;
        alu_b     = b_q;
        case (op_q)
          3'd1: begin alu_s = 4'b0110; alu_cnb = 1'b0; end
          3'd2: begin alu_s = 4'b1011; alu_m = 1'b1; end
          3'd3: begin alu_s = 4'b1110; alu_m = 1'b1; end
          3'd4: begin alu_s = 4'b0110; alu_m = 1'b1; end
          default: ;
        endcase
      end
      MUL: begin
        alu_a = p_q;
        alu_b = b_q[0] ? a_q : 16'h0000;
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        // rsp_valid is registered, so the exit waits for the handshake it enables.
        if (rsp_valid && rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= 3'd0;
      a_q       <= 16'h0000;
      b_q       <= 16'h0000;
      p_q       <= 16'h0000;
      cnt_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_lo    <= 16'h0000;
      rsp_hi    <= 16'h0000;
      rsp_carry <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q      <= req_op;
            a_q       <= req_a;
            b_q       <= req_b;
            p_q       <= 16'h0000;
            cnt_q     <= '0;
            rsp_lo    <= 16'h0000;
            rsp_hi    <= 16'h0000;
            rsp_carry <= 1'b0;
            rsp_err   <= (req_op > 3'd5);
          end
        end
        EXEC: begin
          rsp_lo    <= alu_f;
          rsp_hi    <= 16'h0000;
          rsp_carry <= (op_q <= 3'd1) ? ~alu_cn16b : 1'b0;
        end
        MUL: begin
          p_q   <= p_nxt;
          b_q   <= q_nxt;
          cnt_q <= cnt_q + 1'b1;
          if (last_step) begin
            rsp_hi    <= p_nxt;
            rsp_lo    <= q_nxt;
            rsp_carry <= 1'b0;
          end
        end
        DONE: begin
          if (!rsp_valid)     rsp_valid <= 1'b1;
          else if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu16_seq_ctrl.sv
// tb/tb_alu16_seq_ctrl.sv - self-checking bench for alu16_seq_ctrl with a behavioural 74181 ALU
module tb_alu16_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [2:0]  req_op;
  logic [15:0] req_a, req_b;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_lo, rsp_hi;
  logic        rsp_carry, rsp_err;
  logic [3:0]  alu_s;
  logic        alu_m, alu_cnb;
  logic [15:0] alu_a, alu_b, alu_f;
  logic        alu_cn16b;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] lo;
    logic [15:0] hi;
    logic        c;
    logic        e;
    int          lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  alu16_seq_ctrl #(.MUL_STEPS(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_lo(rsp_lo), .rsp_hi(rsp_hi), .rsp_carry(rsp_carry), .rsp_err(rsp_err),
    .alu_s(alu_s), .alu_m(alu_m), .alu_cnb(alu_cnb),
    .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_cn16b(alu_cn16b)
  );

  // Behavioural 74181 slice (active-high data) for the encodings the controller uses.
  logic [16:0] r;
  always_comb begin
    r         = 17'h0;
    alu_f     = 16'h0;
    alu_cn16b = 1'b1;
    if (!alu_m) begin
      case (alu_s)
        4'b1001: r = {1'b0, alu_a} + {1'b0, alu_b} + {16'h0, ~alu_cnb};
        4'b0110: r = {1'b0, alu_a} + {1'b0, ~alu_b} + {16'h0, ~alu_cnb};
        default: r = 17'h0;
      endcase
      alu_f     = r[15:0];
      alu_cn16b = ~r[16];
    end else begin
      case (alu_s)
        4'b1011: alu_f = alu_a & alu_b;
        4'b1110: alu_f = alu_a | alu_b;
        4'b0110: alu_f = alu_a ^ alu_b;
        default: alu_f = 16'h0;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t x;
    logic [16:0] s;
    logic [31:0] p;
    x = '{lo: 16'h0, hi: 16'h0, c: 1'b0, e: 1'b0, lat: 2};
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; x.lo = s[15:0]; x.c = s[16]; end
      3'd1: begin x.lo = a - b; x.c = (a >= b); end
      3'd2: x.lo = a & b;
      3'd3: x.lo = a | b;
      3'd4: x.lo = a ^ b;
      3'd5: begin p = {16'h0, a} * {16'h0, b}; x.lo = p[15:0]; x.hi = p[31:16]; x.lat = 17; end
      default: begin x.e = 1'b1; x.lat = 1; end
    endcase
    return x;
  endfunction

  function automatic logic [5:0] ctrl_of(input logic [2:0] op);
    // {alu_s, alu_m, alu_cnb}
    case (op)
      3'd1:    return {4'b0110, 1'b0, 1'b0};
      3'd2:    return {4'b1011, 1'b1, 1'b1};
      3'd3:    return {4'b1110, 1'b1, 1'b1};
      3'd4:    return {4'b0110, 1'b1, 1'b1};
      default: return {4'b1001, 1'b0, 1'b1};
    endcase
  endfunction

  task automatic run_op(input string name, input logic [2:0] op, input logic [15:0] a,
                        input logic [15:0] b, input bit hold);
    exp_t x;
    int cyc;
    sb.push_back(model(op, a, b));
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge clk); #1;
    // Scramble the request bus: an in-flight op must not see it.
    req_valid = 1'b0; req_a = 16'($urandom); req_b = 16'($urandom); req_op = 3'($urandom);
    if (op <= 3'd4)
      check({name, "_ctrl"}, {26'h0, alu_s, alu_m, alu_cnb}, {26'h0, ctrl_of(op)});
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!rsp_valid && cyc < 40);
    if (sb.size() == 0) begin
      check({name, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    x = sb.pop_front();
    check({name, "_lat"}, cyc, x.lat);
    check({name, "_lo"}, rsp_lo, x.lo);
    check({name, "_hi"}, rsp_hi, x.hi);
    check({name, "_carry"}, rsp_carry, x.c);
    check({name, "_err"}, rsp_err, x.e);
    if (hold) begin
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd0; req_a = 16'h1111; req_b = 16'h2222;
        @(posedge clk); #1;
        check({name, "_hold_valid"}, rsp_valid, 1'b1);
        check({name, "_hold_ready"}, req_ready, 1'b0);
        check({name, "_hold_res"}, {rsp_hi, rsp_lo}, {x.hi, x.lo});
        check({name, "_hold_flags"}, {rsp_carry, rsp_err}, {x.c, x.e});
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({name, "_rsp_drop"}, rsp_valid, 1'b0);
    check({name, "_idle"}, req_ready, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_a = 16'h0; req_b = 16'h0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp", {rsp_hi, rsp_lo}, 32'h0);
    check("rst_flags", {rsp_carry, rsp_err}, 2'b00);
    check("rst_ctrl", {alu_s, alu_m, alu_cnb}, {4'b1001, 1'b0, 1'b1});
    check("rst_ops", {alu_a, alu_b}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add_ffff_1", 3'd0, 16'hFFFF, 16'h0001, 1'b0);
    run_op("sub_5_7",    3'd1, 16'h0005, 16'h0007, 1'b0);
    run_op("sub_7_5",    3'd1, 16'h0007, 16'h0005, 1'b0);
    run_op("mul_ffff",   3'd5, 16'hFFFF, 16'hFFFF, 1'b0);
    run_op("mul_zero",   3'd5, 16'h1234, 16'h0000, 1'b0);
    run_op("and",        3'd2, 16'hF0F0, 16'hFF00, 1'b0);
    run_op("or",         3'd3, 16'hF0F0, 16'hFF00, 1'b0);
    run_op("xor",        3'd4, 16'hF0F0, 16'hFF00, 1'b0);
    run_op("illegal6",   3'd6, 16'hABCD, 16'h1234, 1'b0);
    run_op("mul_hold",   3'd5, 16'h1234, 16'h5678, 1'b1);
    run_op("illegal7",   3'd7, 16'h0001, 16'h0001, 1'b0);
    for (int k = 0; k < 4; k++)
      run_op("mul_rand", 3'd5, 16'($urandom), 16'($urandom), 1'b0);

    // Abort a multiply half way through with reset.
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd5; req_a = 16'h1234; req_b = 16'h5678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("abort_busy", req_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    check("abort_rsp_valid", rsp_valid, 1'b0);
    check("abort_idle", req_ready, 1'b1);
    check("abort_ctrl", {alu_s, alu_m, alu_cnb, alu_a, alu_b}, {4'b1001, 1'b0, 1'b1, 32'h0});
    @(negedge clk);
    rst_n = 1'b1;
    run_op("add_2_3", 3'd0, 16'h0002, 16'h0003, 1'b0);

    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
